icache_refill_ctrl: RTL and testbench
=====================================

// Module: icache_refill_ctrl
// PURPOSE
// Miss/refill sequencer for the dual-port instruction cache. Arbitrates the two per-port miss signals,
// issues one line-sized request to the memory side, assembles the returned words into a line,
// then writes it into the cache through fetch_addr/fetch_addr_valid/fetched_data.
// Stalls the front end while a refill is outstanding.
// PARAMETERS
// LINE_SIZE   2            32-bit words per cache line; power of 2, >=1
// AW          `ADDR_WIDTH  address width; LB = $clog2(LINE_SIZE*4) line-offset bits
// PORTS
// clk              in   1              clock
// reset            in   1              synchronous, active-high
// miss[2]          in   1 each         per-port miss from cache (port 0 = older instruction)
// miss_addr[2]     in   AW each        byte address of the missing fetch
// ext_flush        in   1              pipeline flush
// refill_stall     out  1              front-end stall request
// busy             out  1              state != IDLE
// mem_req_valid    out  1              line request to memory
// mem_req_addr     out  AW             line-aligned request address
// mem_req_ready    in   1              memory accepts request
// mem_resp_valid   in   1              one 32-bit return beat
// mem_resp_data    in   32             beat data, lowest word first
// fetch_addr       out  AW             line address written to cache
// fetch_addr_valid out  1              one-cycle cache write strobe
// fetched_data     out  32*LINE_SIZE   assembled line; word k at [32k+:32]
// BEHAVIOUR
// - Reset: state IDLE, pending cleared, beat count 0; all outputs 0.
// - line(a) = {a[AW-1:LB], LB'b0}.
// - States: IDLE -> REQ -> WAIT -> FILL -> (REQ if pending, else IDLE).
// - IDLE: on miss[0] and/or miss[1], capture the target line and go to REQ.
//   - Port 0 has priority.
//   - If both miss on different lines: latch line(miss_addr[1]) as pending.
//   - If both miss on the same line: one request only, no pending.
// - REQ: mem_req_valid=1 and mem_req_addr held stable until mem_req_ready. On handshake, go to WAIT with beat count 0.
// - WAIT:
//   - Each mem_resp_valid writes mem_resp_data into word[beat] and increments beat.
//   - After beat LINE_SIZE-1, go to FILL.
//   - mem_resp_valid outside WAIT is ignored.
// - FILL: exactly one cycle.
//   - fetch_addr_valid=1, fetch_addr=current line, fetched_data=assembled line.
//   - fetch_addr and fetched_data hold their values afterwards; fetch_addr_valid returns to 0.
// - refill_stall = (state != IDLE) | ((miss[0] | miss[1]) & ~ext_flush).
//   - It deasserts the cycle after FILL unless pending work or a new miss exists, so the cache re-reads.
// - Miss inputs are sampled only in IDLE. Misses in other states are ignored; the cache re-raises them after refill.
// - ext_flush:
//   - Always clears pending.
//   - In REQ before handshake: abort to IDLE and drop mem_req_valid next cycle.
//   - In WAIT/FILL: complete the refill, because memory cannot cancel and the data is valid; then go to IDLE.
//   - In IDLE: misses in the same cycle are ignored.
// - Mid-operation reset returns to the reset state immediately; stray beats after reset are ignored.
// CONFIGURATION
// ICACHE_NEXT_LINE_PREFETCH_EN defined:
// - After a demand FILL with no pending, issue a prefetch refill of line+LINE_SIZE*4.
//   - Computed modulo 2^AW, so the top line wraps to 0.
// - Prefetch fills never trigger another prefetch.
// - During a prefetch, refill_stall = 0 while in REQ; busy=1.
// - A demand miss in prefetch REQ (before handshake) drops the prefetch and serves the demand line.
// - Once the prefetch handshake occurs, it completes. Demand misses wait and are re-raised by the cache.
// - ext_flush does not cancel an accepted prefetch.
// ICACHE_NEXT_LINE_PREFETCH_EN undefined: after FILL go to pending or IDLE only; no prefetch logic.
// TESTING (LINE_SIZE=2, AW=32)
// 1. miss[0]=1 @0x104, ready=1, beats 0xAAAA0001, 0xBBBB0002
//    -> mem_req_addr=0x100
//    -> one-cycle fetch_addr_valid, fetch_addr=0x100, fetched_data=0xBBBB0002_AAAA0001
//    -> refill_stall low the next cycle.
// 2. miss[0] @0x104 and miss[1] @0x108 in the same cycle
//    -> two requests in order 0x100 then 0x108, two fills, stall held high throughout.
// 3. miss[0] @0x100 and miss[1] @0x104 -> exactly one request (0x100) and one fill.
// 4. mem_req_ready low for 5 cycles -> mem_req_valid=1 and addr 0x100 stable all 5 cycles; one handshake.
// 5. ext_flush in REQ -> IDLE, no fill.
//    ext_flush in WAIT after beat 0 -> fill of the line completes, pending line dropped.
// 6. Macro on:
//    -> fill 0x100 is followed by a prefetch request 0x108 with refill_stall=0.
//    -> miss at 0xFFFFFFFC prefetches 0x00000000.
//    Macro off -> no request after the fill.

Source files
------------

// File: rtl/icache_refill_ctrl.sv
// Miss arbitration and line-refill sequencer for the dual-port instruction cache.
// Optional next-line prefetch is enabled by defining ICACHE_NEXT_LINE_PREFETCH_EN.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif

module icache_refill_ctrl #(
  parameter int LINE_SIZE = 2,
  parameter int AW        = `ADDR_WIDTH
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [1:0]                i_miss,
  input  logic [1:0][AW-1:0]        i_miss_addr,
  input  logic                      i_ext_flush,
  output logic                      o_refill_stall,
  output logic                      o_busy,
  output logic                      o_mem_req_valid,
  output logic [AW-1:0]             o_mem_req_addr,
  input  logic                      i_mem_req_ready,
  input  logic                      i_mem_resp_valid,
  input  logic [31:0]               i_mem_resp_data,
  output logic [AW-1:0]             o_fetch_addr,
  output logic                      o_fetch_addr_valid,
  output logic [32*LINE_SIZE-1:0]   o_fetched_data
);

  localparam int            LB         = $clog2(LINE_SIZE * 4);
  localparam int            BW         = (LINE_SIZE > 1) ? $clog2(LINE_SIZE) : 1;
  localparam logic [AW-1:0] LINE_BYTES = AW'(LINE_SIZE * 4);
  localparam logic [BW-1:0] LAST_BEAT  = BW'(LINE_SIZE - 1);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_FILL} state_t;

  state_t                  r_state, w_state_nxt;
  logic [AW-1:0]           r_line, w_line_nxt;
  logic                    r_pend_v, w_pend_v_nxt;
  logic [AW-1:0]           r_pend_line, w_pend_line_nxt;
  logic [BW-1:0]           r_beat, w_beat_nxt;
  logic [32*LINE_SIZE-1:0] r_words, w_words_nxt;
  logic [AW-1:0]           r_fetch_addr, w_fetch_addr_nxt;
  logic [32*LINE_SIZE-1:0] r_fetched, w_fetched_nxt;
`ifdef ICACHE_NEXT_LINE_PREFETCH_EN
  logic                    r_pf, w_pf_nxt;
  logic                    r_drop, w_drop_nxt;
`endif

  logic [AW-1:0] w_line0, w_line1;
  logic [AW-1:0] w_cap_line;
  logic          w_cap_pend;
  logic          w_take_miss;
  logic          w_hs;
  logic          w_last;
  logic          w_quiet;
  logic          w_unused_offset;

  function automatic logic [AW-1:0] line_of(input logic [AW-1:0] a);
    return {a[AW-1:LB], {LB{1'b0}}};
  endfunction

  assign w_line0     = line_of(i_miss_addr[0]);
  assign w_line1     = line_of(i_miss_addr[1]);
  assign w_take_miss = (|i_miss) & ~i_ext_flush;
  assign w_hs        = (r_state == S_REQ) & i_mem_req_ready;
  assign w_last      = (r_beat == LAST_BEAT);

  // Byte offsets within a line never influence which line is refilled.
  assign w_unused_offset = ^{i_miss_addr[0][LB-1:0], i_miss_addr[1][LB-1:0]};

  // Port 0 is older, so it wins; a distinct port-1 line is queued behind it.
  always_comb begin
    w_cap_line = w_line1;
    w_cap_pend = 1'b0;
    if (i_miss[0]) begin
      w_cap_line = w_line0;
      w_cap_pend = i_miss[1] & (w_line1 != w_line0);
    end
  end

`ifdef ICACHE_NEXT_LINE_PREFETCH_EN
  assign w_quiet = r_pf & (r_state == S_REQ);
`else
  assign w_quiet = 1'b0;
`endif

  // NOTE: every variable gets its default at the top of the block, so no path leaves one unassigned and no latch is inferred.
  always_comb begin
    w_state_nxt      = r_state;
    w_line_nxt       = r_line;
    w_pend_v_nxt     = r_pend_v & ~i_ext_flush;
    w_pend_line_nxt  = r_pend_line;
    w_beat_nxt       = r_beat;
    w_words_nxt      = r_words;
    w_fetch_addr_nxt = r_fetch_addr;
    w_fetched_nxt    = r_fetched;
`ifdef ICACHE_NEXT_LINE_PREFETCH_EN
    w_pf_nxt         = r_pf;
    w_drop_nxt       = r_drop;
`endif

    unique case (r_state)
      S_IDLE: begin
        if (w_take_miss) begin
          w_line_nxt      = w_cap_line;
          w_pend_v_nxt    = w_cap_pend;
          w_pend_line_nxt = w_line1;
          w_state_nxt     = S_REQ;
        end
      end

      S_REQ: begin
        if (w_hs) begin
          w_beat_nxt  = '0;
          w_state_nxt = S_WAIT;
`ifdef ICACHE_NEXT_LINE_PREFETCH_EN
          w_drop_nxt  = 1'b0;
`endif
        end else if (i_ext_flush) begin
          w_state_nxt = S_IDLE;
        end
`ifdef ICACHE_NEXT_LINE_PREFETCH_EN
        else if (r_pf && w_take_miss) begin
          w_line_nxt      = w_cap_line;
          w_pend_v_nxt    = w_cap_pend;
          w_pend_line_nxt = w_line1;
          w_pf_nxt        = 1'b0;
        end
`endif
      end

      S_WAIT: begin
`ifdef ICACHE_NEXT_LINE_PREFETCH_EN
        if (i_ext_flush) w_drop_nxt = 1'b1;
`endif
        if (i_mem_resp_valid) begin
          w_words_nxt[32*int'(r_beat) +: 32] = i_mem_resp_data;
          w_beat_nxt = r_beat + BW'(1);
          if (w_last) begin
            w_fetch_addr_nxt = r_line;
            w_fetched_nxt    = w_words_nxt;
            w_state_nxt      = S_FILL;
          end
        end
      end

      S_FILL: begin
        w_state_nxt = S_IDLE;
        if (r_pend_v && !i_ext_flush) begin
          w_line_nxt   = r_pend_line;
          w_pend_v_nxt = 1'b0;
          w_state_nxt  = S_REQ;
        end
`ifdef ICACHE_NEXT_LINE_PREFETCH_EN
        else if (!r_pf && !r_drop && !i_ext_flush) begin
          w_line_nxt  = r_line + LINE_BYTES;
          w_pf_nxt    = 1'b1;
          w_state_nxt = S_REQ;
        end
`endif
      end

      default: w_state_nxt = S_IDLE;
    endcase

`ifdef ICACHE_NEXT_LINE_PREFETCH_EN
    if (w_state_nxt == S_IDLE) w_pf_nxt = 1'b0;
`endif
  end

  // NOTE: sequential state is written only with non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_line       <= '0;
      r_pend_v     <= 1'b0;
      r_pend_line  <= '0;
      r_beat       <= '0;
      r_fetch_addr <= '0;
      r_fetched    <= '0;
`ifdef ICACHE_NEXT_LINE_PREFETCH_EN
      r_pf         <= 1'b0;
      r_drop       <= 1'b0;
`endif
    end else begin
      r_state      <= w_state_nxt;
      r_line       <= w_line_nxt;
      r_pend_v     <= w_pend_v_nxt;
      r_pend_line  <= w_pend_line_nxt;
      r_beat       <= w_beat_nxt;
      r_fetch_addr <= w_fetch_addr_nxt;
      r_fetched    <= w_fetched_nxt;
`ifdef ICACHE_NEXT_LINE_PREFETCH_EN
      r_pf         <= w_pf_nxt;
      r_drop       <= w_drop_nxt;
`endif
    end
  end

  // NOTE: the assembly buffer has no reset; every word is overwritten before it is copied out at the last beat.
  always_ff @(posedge clk) begin
    r_words <= w_words_nxt;
  end

  assign o_busy             = (r_state != S_IDLE);
  assign o_refill_stall     = (o_busy & ~w_quiet) | w_take_miss;
  assign o_mem_req_valid    = (r_state == S_REQ);
  assign o_mem_req_addr     = r_line;
  assign o_fetch_addr_valid = (r_state == S_FILL);
  assign o_fetch_addr       = r_fetch_addr;
  assign o_fetched_data     = r_fetched;

endmodule

// File: tb/tb_icache_refill_ctrl.sv
// Self-checking bench for icache_refill_ctrl (LINE_SIZE=2, AW=32): vector table,
// randomized transactions against a transaction-level model, and hand-written corner sequences.
module tb_icache_refill_ctrl;
  localparam int LS = 2;
  localparam int AW = 32;

  logic              clk = 1'b0;
  logic              reset;
  logic [1:0]        i_miss;
  logic [1:0][31:0]  i_miss_addr;
  logic              i_ext_flush;
  logic              o_refill_stall, o_busy, o_mem_req_valid;
  logic [31:0]       o_mem_req_addr;
  logic              i_mem_req_ready, i_mem_resp_valid;
  logic [31:0]       i_mem_resp_data;
  logic [31:0]       o_fetch_addr;
  logic              o_fetch_addr_valid;
  logic [63:0]       o_fetched_data;

  always #5 clk = ~clk;

  icache_refill_ctrl #(.LINE_SIZE(LS), .AW(AW)) dut (
    .clk(clk), .reset(reset), .i_miss(i_miss), .i_miss_addr(i_miss_addr),
    .i_ext_flush(i_ext_flush), .o_refill_stall(o_refill_stall), .o_busy(o_busy),
    .o_mem_req_valid(o_mem_req_valid), .o_mem_req_addr(o_mem_req_addr),
    .i_mem_req_ready(i_mem_req_ready), .i_mem_resp_valid(i_mem_resp_valid),
    .i_mem_resp_data(i_mem_resp_data), .o_fetch_addr(o_fetch_addr),
    .o_fetch_addr_valid(o_fetch_addr_valid), .o_fetched_data(o_fetched_data)
  );

  int checks = 0;
  int failures = 0;

  bit          manual_mem;
  int          ready_pct, beat_pct;
  logic [31:0] cur_line;
  int          beats_left, beat_idx;
  logic [31:0] req_q[$];
  logic [31:0] fill_addr_q[$];
  logic [63:0] fill_data_q[$];

  typedef struct {
    logic [1:0]  miss;
    logic [31:0] a0, a1;
    logic        flush;
    logic        exp_stall;
    int          n;
    logic [31:0] l0, l1;
    int          rp, bp;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] line_of(input logic [31:0] a);
    return a & ~32'h7;
  endfunction

  // Memory contents as a pure function of line address and word index.
  function automatic logic [31:0] mem_word(input logic [31:0] line, input int k);
    return (line ^ 32'h5A5A_0000) + 32'h0101_0101 * (k + 1);
  endfunction

  function automatic logic [63:0] line_data(input logic [31:0] line);
    return {mem_word(line, 1), mem_word(line, 0)};
  endfunction

  // One clock: record handshakes and fills mid-cycle, then drive memory-side inputs after the edge.
  task automatic tick();
    @(negedge clk);
    if (o_mem_req_valid && i_mem_req_ready) begin
      req_q.push_back(o_mem_req_addr);
      cur_line   = o_mem_req_addr;
      beats_left = LS;
      beat_idx   = 0;
    end
    if (o_fetch_addr_valid) begin
      fill_addr_q.push_back(o_fetch_addr);
      fill_data_q.push_back(o_fetched_data);
    end
    @(posedge clk);
    #1;
    if (!manual_mem) begin
      i_mem_req_ready  = ($urandom_range(0, 99) < ready_pct);
      i_mem_resp_valid = 1'b0;
      if (beats_left > 0 && $urandom_range(0, 99) < beat_pct) begin
        i_mem_resp_valid = 1'b1;
        i_mem_resp_data  = mem_word(cur_line, beat_idx);
        beat_idx++;
        beats_left--;
      end
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    i_miss = '0; i_miss_addr = '0; i_ext_flush = 1'b0;
    i_mem_req_ready = 1'b0; i_mem_resp_valid = 1'b0; i_mem_resp_data = '0;
    manual_mem = 1'b1; beats_left = 0; beat_idx = 0; cur_line = '0;
    repeat (3) tick();
    reset = 1'b0;
    req_q.delete(); fill_addr_q.delete(); fill_data_q.delete();
  endtask

  task automatic pulse_miss(input logic [1:0] m, input logic [31:0] a0, input logic [31:0] a1,
                            input logic fl, output logic stall);
    i_miss = m; i_miss_addr[0] = a0; i_miss_addr[1] = a1; i_ext_flush = fl;
    #1;
    stall = o_refill_stall;
    tick();
    i_miss = '0; i_ext_flush = 1'b0;
  endtask

  task automatic wait_idle(input string name, input int n_demand, output int drops);
    int n = 0;
    drops = 0;
    while (o_busy && n < 400) begin
      if (fill_addr_q.size() < n_demand && !o_refill_stall) drops++;
      tick();
      n++;
    end
    if (o_busy) check({name, " idle timeout"}, o_busy, 1'b0);
    repeat (6) tick();
  endtask

  task automatic run_scenario(input string name, input vec_t v);
    logic [31:0] exp_q[$];
    logic stall;
    int drops;
    do_reset();
    manual_mem = 1'b0; ready_pct = v.rp; beat_pct = v.bp;
    if (v.n >= 1) exp_q.push_back(v.l0);
    if (v.n >= 2) exp_q.push_back(v.l1);
`ifdef ICACHE_NEXT_LINE_PREFETCH_EN
    if (v.n > 0) exp_q.push_back(exp_q[exp_q.size()-1] + 32'd8);
`endif
    pulse_miss(v.miss, v.a0, v.a1, v.flush, stall);
    check({name, " stall"}, stall, v.exp_stall);
    wait_idle(name, v.n, drops);
    check({name, " stall held"}, drops, 0);
    check({name, " nreq"}, req_q.size(), exp_q.size());
    check({name, " nfill"}, fill_addr_q.size(), exp_q.size());
    foreach (exp_q[i]) begin
      if (i < req_q.size()) check($sformatf("%s req%0d", name, i), req_q[i], exp_q[i]);
      if (i < fill_addr_q.size()) begin
        check($sformatf("%s fill%0d addr", name, i), fill_addr_q[i], exp_q[i]);
        check($sformatf("%s fill%0d data", name, i), fill_data_q[i], line_data(exp_q[i]));
      end
    end
  endtask

  // Single demand refill with explicit beats; request held with ready low for five cycles.
  task automatic run_refill_manual(input string name, input logic [31:0] a,
                                   input logic [31:0] w0, input logic [31:0] w1);
    logic stall;
    manual_mem = 1'b1;
    i_mem_req_ready = 1'b0;
    i_mem_resp_valid = 1'b1; i_mem_resp_data = 32'hDEAD_BEEF;
    tick();
    i_mem_resp_valid = 1'b0;
    pulse_miss(2'b01, a, 32'h0, 1'b0, stall);
    check({name, " miss stall"}, stall, 1'b1);
    for (int k = 0; k < 5; k++) begin
      check($sformatf("%s req hold%0d", name, k), {o_mem_req_valid, o_mem_req_addr}, {1'b1, line_of(a)});
      tick();
    end
    i_mem_req_ready = 1'b1;
    tick();
    i_mem_req_ready = 1'b0;
    check({name, " one handshake"}, req_q.size(), 1);
    i_mem_resp_valid = 1'b1; i_mem_resp_data = w0;
    tick();
    i_mem_resp_data = w1;
    tick();
    i_mem_resp_valid = 1'b0;
    check({name, " fill strobe"}, o_fetch_addr_valid, 1'b1);
    check({name, " fill addr"}, o_fetch_addr, line_of(a));
    check({name, " fill data"}, o_fetched_data, {w1, w0});
    tick();
    check({name, " strobe drop"}, o_fetch_addr_valid, 1'b0);
    check({name, " data hold"}, {o_fetch_addr, o_fetched_data}, {line_of(a), w1, w0});
    check({name, " stall after"}, o_refill_stall, 1'b0);
`ifdef ICACHE_NEXT_LINE_PREFETCH_EN
    check({name, " prefetch req"}, {o_busy, o_mem_req_valid, o_mem_req_addr}, {2'b11, line_of(a) + 32'd8});
`else
    check({name, " no req after"}, {o_busy, o_mem_req_valid}, 2'b00);
`endif
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic stall;
    vec_t rv;

    vecs[0] = '{2'b01, 32'h104,      32'h0,   1'b0, 1'b1, 1, 32'h100,      32'h0,   100, 100};
    vecs[1] = '{2'b11, 32'h104,      32'h108, 1'b0, 1'b1, 2, 32'h100,      32'h108, 100, 100};
    vecs[2] = '{2'b11, 32'h100,      32'h104, 1'b0, 1'b1, 1, 32'h100,      32'h0,   100, 100};
    vecs[3] = '{2'b10, 32'h0,        32'h20C, 1'b0, 1'b1, 1, 32'h208,      32'h0,   60,  50};
    vecs[4] = '{2'b11, 32'h104,      32'h108, 1'b1, 1'b0, 0, 32'h0,        32'h0,   100, 100};
    vecs[5] = '{2'b01, 32'hFFFFFFFC, 32'h0,   1'b0, 1'b1, 1, 32'hFFFFFFF8, 32'h0,   100, 100};
    vecs[6] = '{2'b11, 32'h500,      32'h404, 1'b0, 1'b1, 2, 32'h500,      32'h400, 40,  40};

    // Reset state.
    do_reset();
    check("reset busy", o_busy, 1'b0);
    check("reset stall", o_refill_stall, 1'b0);
    check("reset req", {o_mem_req_valid, o_mem_req_addr}, 33'h0);
    check("reset fill", {o_fetch_addr_valid, o_fetch_addr}, 33'h0);
    check("reset data", o_fetched_data, 64'h0);

    // Basic refill, held request, exact beat assembly, prefetch or quiet afterwards.
    run_refill_manual("basic", 32'h104, 32'hAAAA0001, 32'hBBBB0002);
`ifdef ICACHE_NEXT_LINE_PREFETCH_EN
    // A demand miss before the prefetch handshake replaces the prefetch.
    pulse_miss(2'b01, 32'h304, 32'h0, 1'b0, stall);
    check("pf preempt req", {o_mem_req_valid, o_mem_req_addr}, {1'b1, 32'h300});
    check("pf preempt stall", o_refill_stall, 1'b1);
    manual_mem = 1'b0; ready_pct = 100; beat_pct = 100;
    begin
      int drops;
      wait_idle("pf preempt", 0, drops);
    end
    check("pf preempt nreq", req_q.size(), 3);
    if (req_q.size() == 3) check("pf preempt lines", {req_q[1], req_q[2]}, {32'h300, 32'h308});
`endif

    // Vector table.
    foreach (vecs[i]) run_scenario($sformatf("vec%0d", i), vecs[i]);

    // Flush in REQ before handshake aborts with no fill.
    do_reset();
    manual_mem = 1'b0; ready_pct = 0; beat_pct = 100;
    pulse_miss(2'b01, 32'h104, 32'h0, 1'b0, stall);
    check("flush req valid", o_mem_req_valid, 1'b1);
    i_ext_flush = 1'b1;
    tick();
    i_ext_flush = 1'b0;
    check("flush req abort", {o_busy, o_mem_req_valid}, 2'b00);
    ready_pct = 100;
    repeat (6) tick();
    check("flush req nreq", req_q.size(), 0);
    check("flush req nfill", fill_addr_q.size(), 0);

    // Flush in WAIT after beat 0: line completes, pending line dropped.
    do_reset();
    i_mem_req_ready = 1'b1;
    pulse_miss(2'b11, 32'h104, 32'h208, 1'b0, stall);
    tick();
    i_mem_req_ready = 1'b0;
    i_mem_resp_valid = 1'b1; i_mem_resp_data = 32'h1234_0000;
    tick();
    i_mem_resp_valid = 1'b0; i_ext_flush = 1'b1;
    tick();
    i_ext_flush = 1'b0; i_mem_resp_valid = 1'b1; i_mem_resp_data = 32'h5678_0001;
    tick();
    i_mem_resp_valid = 1'b0;
    check("flush wait fill", {o_fetch_addr_valid, o_fetch_addr}, {1'b1, 32'h100});
    check("flush wait data", o_fetched_data, 64'h5678_0001_1234_0000);
    manual_mem = 1'b0; ready_pct = 100; beat_pct = 100;
    repeat (8) tick();
    check("flush wait nreq", req_q.size(), 1);
    check("flush wait nfill", fill_addr_q.size(), 1);
    check("flush wait idle", o_busy, 1'b0);

    // Reset in the middle of WAIT; stray beats around it are ignored.
    do_reset();
    i_mem_req_ready = 1'b1;
    pulse_miss(2'b01, 32'h204, 32'h0, 1'b0, stall);
    tick();
    i_mem_req_ready = 1'b0;
    i_mem_resp_valid = 1'b1; i_mem_resp_data = 32'hCAFE_0000;
    tick();
    reset = 1'b1;
    repeat (2) tick();
    reset = 1'b0;
    tick();
    i_mem_resp_valid = 1'b0;
    repeat (2) tick();
    check("midreset idle", {o_busy, o_refill_stall, o_mem_req_valid}, 3'b000);
    check("midreset nofill", fill_addr_q.size(), 0);
    check("midreset data", {o_fetch_addr, o_fetched_data}, 96'h0);
    req_q.delete();
    run_refill_manual("post reset", 32'h40C, 32'h1111_1111, 32'h2222_2222);

    // Randomized transactions against the transaction-level model.
    for (int it = 0; it < 30; it++) begin
      rv.miss  = 2'($urandom_range(1, 3));
      rv.a0    = $urandom;
      rv.a1    = ($urandom_range(0, 2) == 0) ? (rv.a0 ^ 32'($urandom_range(0, 7))) : $urandom;
      rv.flush = ($urandom_range(0, 9) == 0);
      rv.rp    = $urandom_range(20, 100);
      rv.bp    = $urandom_range(20, 100);
      rv.exp_stall = !rv.flush;
      rv.n = 0; rv.l0 = '0; rv.l1 = '0;
      if (!rv.flush) begin
        if (rv.miss[0]) begin
          rv.l0 = line_of(rv.a0);
          rv.n  = 1;
          if (rv.miss[1] && line_of(rv.a1) != rv.l0) begin
            rv.l1 = line_of(rv.a1);
            rv.n  = 2;
          end
        end else begin
          rv.l0 = line_of(rv.a1);
          rv.n  = 1;
        end
      end
      run_scenario($sformatf("rand%0d", it), rv);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
